// File: rtl/raid_pkg.sv
// Shared types and constants for the RAID stripe parity datapath
// (parity calculator on the write side, reconstructor on the read side).
package raid_pkg;

  localparam int unsigned DEF_DATA_W = 12;
  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_CNT_W  = 16;
  localparam int unsigned FAIL_W     = 3;

  localparam int unsigned FAIL_D0 = 0;
  localparam int unsigned FAIL_D1 = 1;
  localparam int unsigned FAIL_P  = 2;

  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_REBUILT  = 2'b01,
    ST_MISMATCH = 2'b10,
    ST_UNRECOV  = 2'b11
  } status_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EVAL = 2'b01,
    S_HOLD = 2'b10
  } state_t;

  // Number of failed drives flagged in a mask.
  function automatic logic [1:0] fail_count(input logic [FAIL_W-1:0] mask);
    return 2'(mask[FAIL_D0]) + 2'(mask[FAIL_D1]) + 2'(mask[FAIL_P]);
  endfunction

endpackage

// File: rtl/parity_reconstructor.sv
// Read-path stripe checker: verifies D0^D1 == P, rebuilds a single lost data
// word from the survivor and parity, or flags the stripe unrecoverable.
module parity_reconstructor
  import raid_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] address_in,
  input  logic [DATA_W-1:0] D0_in,
  input  logic [DATA_W-1:0] D1_in,
  input  logic [DATA_W-1:0] P_in,
  input  logic [FAIL_W-1:0] fail_mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] address_out,
  output logic [DATA_W-1:0] D0_out,
  output logic [DATA_W-1:0] D1_out,
  output logic [1:0]        status,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic [CNT_W-1:0]  rebuild_cnt,
  input  logic              clear_cnt
);

  state_t              state;
  state_t              state_nxt;
  status_t             status_q;

  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   d0_q;
  logic [DATA_W-1:0]   d1_q;
  logic [DATA_W-1:0]   p_q;
  logic [FAIL_W-1:0]   mask_q;

  logic [DATA_W-1:0]   res_d0;
  logic [DATA_W-1:0]   res_d1;
  status_t             res_status;
  logic                inc_mis;
  logic                inc_reb;

  assign status = status_q;

  // Rebuild selection on the captured stripe.
  always_comb begin
    res_d0     = d0_q;
    res_d1     = d1_q;
    res_status = ST_OK;
    inc_mis    = 1'b0;
    inc_reb    = 1'b0;
    if (fail_count(mask_q) > 2'd1) begin
      res_d0     = '0;
      res_d1     = '0;
      res_status = ST_UNRECOV;
    end else if (mask_q[FAIL_D0]) begin
      res_d0     = d1_q ^ p_q;
      res_status = ST_REBUILT;
      inc_reb    = 1'b1;
    end else if (mask_q[FAIL_D1]) begin
      res_d1     = d0_q ^ p_q;
      res_status = ST_REBUILT;
      inc_reb    = 1'b1;
    end else if (mask_q[FAIL_P]) begin
      // Parity drive lost: nothing to check against, data passes through.
      res_status = ST_OK;
    end else if ((d0_q ^ d1_q) != p_q) begin
      res_status = ST_MISMATCH;
      inc_mis    = 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid && in_ready) state_nxt = S_EVAL;
      S_EVAL:  state_nxt = S_HOLD;
      S_HOLD:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM state, capture, result and statistics registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      addr_q       <= '0;
      d0_q         <= '0;
      d1_q         <= '0;
      p_q          <= '0;
      mask_q       <= '0;
      address_out  <= '0;
      D0_out       <= '0;
      D1_out       <= '0;
      status_q     <= ST_OK;
      mismatch_cnt <= '0;
      rebuild_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt == S_IDLE);

      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            addr_q <= address_in;
            d0_q   <= D0_in;
            d1_q   <= D1_in;
            p_q    <= P_in;
            mask_q <= fail_mask;
          end
        end
        S_EVAL: begin
          address_out <= addr_q;
          D0_out      <= res_d0;
          D1_out      <= res_d1;
          status_q    <= res_status;
          out_valid   <= 1'b1;
        end
        S_HOLD: begin
          if (out_ready) begin
            address_out <= '0;
            D0_out      <= '0;
            D1_out      <= '0;
            status_q    <= ST_OK;
            out_valid   <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase

      // Clear beats a same-cycle increment; counters stick at all-ones.
      if (clear_cnt) begin
        mismatch_cnt <= '0;
        rebuild_cnt  <= '0;
      end else if (state == S_EVAL) begin
        if (inc_mis && (mismatch_cnt != '1)) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
        if (inc_reb && (rebuild_cnt != '1))  rebuild_cnt  <= rebuild_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_parity_reconstructor.sv
// Self-checking bench for parity_reconstructor; a second instance with 3-bit
// counters shares all inputs so saturation is reachable in a few stripes.
module tb_parity_reconstructor;
  import raid_pkg::*;

  localparam int unsigned DW  = 12;
  localparam int unsigned AW  = 8;
  localparam int unsigned CW  = 16;
  localparam int unsigned SCW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, out_valid, out_ready, clear_cnt;
  logic [AW-1:0] address_in, address_out;
  logic [DW-1:0] D0_in, D1_in, P_in, D0_out, D1_out;
  logic [2:0]    fail_mask;
  logic [1:0]    status;
  logic [CW-1:0] mismatch_cnt, rebuild_cnt;

  logic           s_in_ready, s_out_valid;
  logic [AW-1:0]  s_address_out;
  logic [DW-1:0]  s_D0_out, s_D1_out;
  logic [1:0]     s_status;
  logic [SCW-1:0] s_mismatch_cnt, s_rebuild_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_mis, exp_reb, exp_mis_s, exp_reb_s;

  always #5 clk = ~clk;

  parity_reconstructor u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .address_in(address_in), .D0_in(D0_in), .D1_in(D1_in), .P_in(P_in),
    .fail_mask(fail_mask), .out_valid(out_valid), .out_ready(out_ready),
    .address_out(address_out), .D0_out(D0_out), .D1_out(D1_out),
    .status(status), .mismatch_cnt(mismatch_cnt), .rebuild_cnt(rebuild_cnt),
    .clear_cnt(clear_cnt)
  );

  parity_reconstructor #(.CNT_W(SCW)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .address_in(address_in), .D0_in(D0_in), .D1_in(D1_in), .P_in(P_in),
    .fail_mask(fail_mask), .out_valid(s_out_valid), .out_ready(out_ready),
    .address_out(s_address_out), .D0_out(s_D0_out), .D1_out(s_D1_out),
    .status(s_status), .mismatch_cnt(s_mismatch_cnt), .rebuild_cnt(s_rebuild_cnt),
    .clear_cnt(clear_cnt)
  );

  // Reference: outcome of a stripe by the number of failed drives.
  // kind: 0 no count, 1 mismatch, 2 rebuild.
  function automatic void model(input logic [DW-1:0] d0, d1, p, input logic [2:0] m,
                                output logic [DW-1:0] e0, e1, output logic [1:0] est,
                                output int kind);
    e0 = d0; e1 = d1; est = 2'b00; kind = 0;
    if ($countones(m) >= 2) begin
      e0 = '0; e1 = '0; est = 2'b11;
    end else if (m == 3'b001) begin
      e0 = d1 ^ p; est = 2'b01; kind = 2;
    end else if (m == 3'b010) begin
      e1 = d0 ^ p; est = 2'b01; kind = 2;
    end else if (m == 3'b000 && (d0 ^ d1) != p) begin
      est = 2'b10; kind = 1;
    end
  endfunction

  function automatic void count(input int kind);
    if (kind == 1) begin
      if (exp_mis < 65535) exp_mis++;
      if (exp_mis_s < 7) exp_mis_s++;
    end else if (kind == 2) begin
      if (exp_reb < 65535) exp_reb++;
      if (exp_reb_s < 7) exp_reb_s++;
    end
  endfunction

  // Presents a stripe and returns at the negedge of the EVAL cycle.
  task automatic accept_stripe(input logic [AW-1:0] a, input logic [DW-1:0] d0, d1, p,
                               input logic [2:0] m, output bit ok);
    int n = 0;
    address_in = a; D0_in = d0; D1_in = d1; P_in = p; fail_mask = m;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Waits for out_valid; lat counts cycles after the accept edge.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || address_out !== '0 || D0_out !== '0 ||
        D1_out !== '0 || status !== 2'b00 || mismatch_cnt !== '0 || rebuild_cnt !== '0) begin
      $display("FAIL reset_state: rdy=%b vld=%b a=%h d0=%h d1=%h st=%b mc=%0d rc=%0d, need rdy=1 rest 0",
               in_ready, out_valid, address_out, D0_out, D1_out, status, mismatch_cnt, rebuild_cnt);
      failures++;
    end
    checks++;
  endtask

  task automatic test_directed;
    logic [DW-1:0] vd0 [7] = '{12'hA5C, 12'h000, 12'hA5C, 12'hA5C, 12'hA5C, 12'hA5C, 12'hA5C};
    logic [DW-1:0] vd1 [7] = '{12'h3F0, 12'h3F0, 12'h000, 12'h3F0, 12'h3F0, 12'h3F0, 12'h3F0};
    logic [DW-1:0] vp  [7] = '{12'h9AC, 12'h9AC, 12'h9AC, 12'h9AD, 12'h9AD, 12'h9AC, 12'h9AC};
    logic [2:0]    vm  [7] = '{3'b000, 3'b001, 3'b010, 3'b000, 3'b100, 3'b011, 3'b111};
    logic [DW-1:0] x0  [7] = '{12'hA5C, 12'hA5C, 12'hA5C, 12'hA5C, 12'hA5C, 12'h000, 12'h000};
    logic [DW-1:0] x1  [7] = '{12'h3F0, 12'h3F0, 12'h3F0, 12'h3F0, 12'h3F0, 12'h000, 12'h000};
    logic [1:0]    xs  [7] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b00, 2'b11, 2'b11};
    int            xmc [7] = '{0, 0, 0, 1, 1, 1, 1};
    int            xrc [7] = '{0, 1, 2, 2, 2, 2, 2};
    bit ok;
    int lat;
    for (int i = 0; i < 7; i++) begin
      accept_stripe(AW'(8'h10 + i), vd0[i], vd1[i], vp[i], vm[i], ok);
      wait_result(lat);
      if (!ok || lat != 2) begin
        $display("FAIL dir_latency[%0d]: got %0d cycles accepted=%0d, need 2", i, lat, ok);
        failures++;
      end
      checks++;
      if (D0_out !== x0[i] || D1_out !== x1[i] || status !== xs[i] || address_out !== AW'(8'h10 + i)) begin
        $display("FAIL dir_result[%0d]: d0=%h d1=%h st=%b a=%h, need d0=%h d1=%h st=%b a=%h",
                 i, D0_out, D1_out, status, address_out, x0[i], x1[i], xs[i], AW'(8'h10 + i));
        failures++;
      end
      checks++;
      if (mismatch_cnt !== CW'(xmc[i]) || rebuild_cnt !== CW'(xrc[i]) || in_ready !== 1'b0) begin
        $display("FAIL dir_counts[%0d]: mc=%0d rc=%0d rdy=%b, need mc=%0d rc=%0d rdy=0",
                 i, mismatch_cnt, rebuild_cnt, in_ready, xmc[i], xrc[i]);
        failures++;
      end
      checks++;
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || D0_out !== '0 || D1_out !== '0 ||
          status !== 2'b00 || address_out !== '0) begin
        $display("FAIL dir_release[%0d]: vld=%b rdy=%b d0=%h d1=%h st=%b a=%h, need vld=0 rdy=1 rest 0",
                 i, out_valid, in_ready, D0_out, D1_out, status, address_out);
        failures++;
      end
      checks++;
    end
    exp_mis = 1; exp_reb = 2; exp_mis_s = 1; exp_reb_s = 2;
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] c0, c1;
    logic [1:0]    cs;
    logic [AW-1:0] ca;
    bit ok;
    int lat;
    out_ready = 1'b0;
    accept_stripe(8'h77, 12'h123, 12'h456, 12'h123 ^ 12'h456, 3'b000, ok);
    wait_result(lat);
    c0 = D0_out; c1 = D1_out; cs = status; ca = address_out;
    if (!ok || lat != 2 || c0 !== 12'h123 || c1 !== 12'h456 || cs !== 2'b00 || ca !== 8'h77) begin
      $display("FAIL bp_result: lat=%0d d0=%h d1=%h st=%b a=%h, need lat=2 d0=123 d1=456 st=00 a=77",
               lat, c0, c1, cs, ca);
      failures++;
    end
    checks++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || D0_out !== c0 || D1_out !== c1 ||
          status !== cs || address_out !== ca) begin
        $display("FAIL bp_hold[%0d]: vld=%b rdy=%b d0=%h d1=%h st=%b a=%h, need vld=1 rdy=0 frozen",
                 i, out_valid, in_ready, D0_out, D1_out, status, address_out);
        failures++;
      end
      checks++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL bp_release: vld=%b rdy=%b, need vld=0 rdy=1", out_valid, in_ready);
      failures++;
    end
    checks++;
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] e0, e1;
    logic [1:0]    es;
    int kind, sent, got, cyc, last;
    bit will, overlap;
    logic [DW-1:0] qd0 [4] = '{12'h111, 12'h000, 12'hABC, 12'h0F0};
    logic [DW-1:0] qd1 [4] = '{12'h222, 12'h555, 12'h000, 12'h00F};
    logic [DW-1:0] qp  [4] = '{12'h333, 12'hFFF, 12'h123, 12'h0FE};
    logic [2:0]    qm  [4] = '{3'b000, 3'b001, 3'b010, 3'b000};
    sent = 0; got = 0; cyc = 0; last = -1; overlap = 1'b0;
    address_in = 8'h40; D0_in = qd0[0]; D1_in = qd1[0]; P_in = qp[0]; fail_mask = qm[0];
    in_valid = 1'b1;
    while (got < 4 && cyc < 40) begin
      will = in_valid && in_ready;
      @(negedge clk);
      cyc++;
      if (in_ready && out_valid) overlap = 1'b1;
      if (will) begin
        sent++;
        if (sent < 4) begin
          address_in = AW'(8'h40 + sent); D0_in = qd0[sent]; D1_in = qd1[sent];
          P_in = qp[sent]; fail_mask = qm[sent];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        model(qd0[got], qd1[got], qp[got], qm[got], e0, e1, es, kind);
        count(kind);
        if (D0_out !== e0 || D1_out !== e1 || status !== es || address_out !== AW'(8'h40 + got)) begin
          $display("FAIL b2b_result[%0d]: d0=%h d1=%h st=%b a=%h, need d0=%h d1=%h st=%b",
                   got, D0_out, D1_out, status, address_out, e0, e1, es);
          failures++;
        end
        checks++;
        got++;
        last = cyc;
      end
    end
    in_valid = 1'b0;
    if (got != 4 || last != 11 || overlap) begin
      $display("FAIL b2b_timing: results=%0d last_valid_cycle=%0d overlap=%0d, need 4, 11, 0",
               got, last, overlap);
      failures++;
    end
    checks++;
    @(negedge clk);
    if (mismatch_cnt !== CW'(exp_mis) || rebuild_cnt !== CW'(exp_reb) || in_ready !== 1'b1) begin
      $display("FAIL b2b_counts: mc=%0d rc=%0d rdy=%b, need mc=%0d rc=%0d rdy=1",
               mismatch_cnt, rebuild_cnt, in_ready, exp_mis, exp_reb);
      failures++;
    end
    checks++;
  endtask

  task automatic test_reset_in_eval;
    bit ok;
    bit seen = 1'b0;
    accept_stripe(8'h99, 12'h000, 12'h3F0, 12'h9AC, 3'b001, ok);
    reset = 1'b1;
    #1;
    if (!ok || out_valid !== 1'b0 || in_ready !== 1'b1 || D0_out !== '0 || status !== 2'b00 ||
        mismatch_cnt !== '0 || rebuild_cnt !== '0) begin
      $display("FAIL reset_eval_async: vld=%b rdy=%b d0=%h st=%b mc=%0d rc=%0d, need vld=0 rdy=1 rest 0",
               out_valid, in_ready, D0_out, status, mismatch_cnt, rebuild_cnt);
      failures++;
    end
    checks++;
    exp_mis = 0; exp_reb = 0; exp_mis_s = 0; exp_reb_s = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid || rebuild_cnt != '0 || !in_ready) seen = 1'b1;
    end
    if (seen) begin
      $display("FAIL reset_eval_stale: stale activity after reset (vld=%b rc=%0d rdy=%b), need none",
               out_valid, rebuild_cnt, in_ready);
      failures++;
    end
    checks++;
  endtask

  task automatic test_clear_rebuild;
    bit ok;
    int lat;
    accept_stripe(8'h01, 12'h000, 12'h3F0, 12'h9AC, 3'b001, ok);
    wait_result(lat);
    @(negedge clk);
    count(2);
    if (rebuild_cnt !== CW'(exp_reb) || exp_reb != 1) begin
      $display("FAIL clear_pre: rc=%0d, need 1", rebuild_cnt);
      failures++;
    end
    checks++;
    accept_stripe(8'h02, 12'hA5C, 12'h000, 12'h9AC, 3'b010, ok);
    clear_cnt = 1'b1;
    @(negedge clk);
    clear_cnt = 1'b0;
    exp_mis = 0; exp_reb = 0; exp_mis_s = 0; exp_reb_s = 0;
    if (out_valid !== 1'b1 || status !== 2'b01 || D1_out !== 12'h3F0 || rebuild_cnt !== '0 ||
        s_rebuild_cnt !== '0) begin
      $display("FAIL clear_wins: vld=%b st=%b d1=%h rc=%0d src=%0d, need vld=1 st=01 d1=3f0 rc=0 src=0",
               out_valid, status, D1_out, rebuild_cnt, s_rebuild_cnt);
      failures++;
    end
    checks++;
    @(negedge clk);
  endtask

  task automatic test_saturation;
    bit ok;
    int lat;
    for (int i = 0; i < 9; i++) begin
      accept_stripe(AW'(i), 12'h000, 12'h0AA, 12'h555, 3'b001, ok);
      wait_result(lat);
      count(2);
      accept_stripe(AW'(i), 12'h001, 12'h002, 12'h004, 3'b000, ok);
      wait_result(lat);
      count(1);
    end
    if (s_rebuild_cnt !== 3'd7 || s_mismatch_cnt !== 3'd7 || exp_reb_s != 7) begin
      $display("FAIL saturate: sat rc=%0d mc=%0d, need 7 7", s_rebuild_cnt, s_mismatch_cnt);
      failures++;
    end
    checks++;
    if (rebuild_cnt !== CW'(exp_reb) || mismatch_cnt !== CW'(exp_mis)) begin
      $display("FAIL saturate_wide: rc=%0d mc=%0d, need %0d %0d", rebuild_cnt, mismatch_cnt, exp_reb, exp_mis);
      failures++;
    end
    checks++;
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [DW-1:0] d0, d1, p, e0, e1;
    logic [AW-1:0] a;
    logic [2:0]    m;
    logic [1:0]    es;
    int kind, lat, hold;
    bit ok, bad;
    for (int i = 0; i < 40; i++) begin
      a = AW'($urandom); d0 = DW'($urandom); d1 = DW'($urandom); m = 3'($urandom);
      p = ($urandom_range(0, 1) == 0) ? (d0 ^ d1) : DW'($urandom);
      hold = $urandom_range(0, 2);
      model(d0, d1, p, m, e0, e1, es, kind);
      count(kind);
      out_ready = (hold == 0);
      accept_stripe(a, d0, d1, p, m, ok);
      wait_result(lat);
      if (!ok || lat != 2 || D0_out !== e0 || D1_out !== e1 || status !== es || address_out !== a) begin
        $display("FAIL rand_result[%0d]: lat=%0d d0=%h d1=%h st=%b a=%h, need lat=2 d0=%h d1=%h st=%b a=%h",
                 i, lat, D0_out, D1_out, status, address_out, e0, e1, es, a);
        failures++;
      end
      checks++;
      if (mismatch_cnt !== CW'(exp_mis) || rebuild_cnt !== CW'(exp_reb) ||
          s_mismatch_cnt !== SCW'(exp_mis_s) || s_rebuild_cnt !== SCW'(exp_reb_s)) begin
        $display("FAIL rand_counts[%0d]: mc=%0d rc=%0d smc=%0d src=%0d, need %0d %0d %0d %0d",
                 i, mismatch_cnt, rebuild_cnt, s_mismatch_cnt, s_rebuild_cnt,
                 exp_mis, exp_reb, exp_mis_s, exp_reb_s);
        failures++;
      end
      checks++;
      bad = 1'b0;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (!out_valid || in_ready || D0_out !== e0 || D1_out !== e1 || status !== es) bad = 1'b1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      if (bad || out_valid !== 1'b0 || in_ready !== 1'b1 || D0_out !== '0 || status !== 2'b00) begin
        $display("FAIL rand_handshake[%0d]: hold_broken=%0d vld=%b rdy=%b d0=%h st=%b, need 0 0 1 0 0",
                 i, bad, out_valid, in_ready, D0_out, status);
        failures++;
      end
      checks++;
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clear_cnt = 1'b0;
    address_in = '0; D0_in = '0; D1_in = '0; P_in = '0; fail_mask = '0;
    exp_mis = 0; exp_reb = 0; exp_mis_s = 0; exp_reb_s = 0;
    repeat (3) @(negedge clk);
    test_reset;
    reset = 1'b0;
    @(negedge clk);
    test_directed;
    test_backpressure;
    test_back_to_back;
    test_reset_in_eval;
    test_clear_rebuild;
    test_saturation;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
